fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS core: owns the PC, issues word reads to the synchronous instruction memory, and buffers returned instructions in a prefetch queue that feeds the decoder over a valid/ready handshake. It replaces the free-running PC-increment fetch loop and adds stall, redirect/flush and a multi-entry prefetch buffer.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Fetch state encoding, reset PC default and instruction width.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_BASE_DEFAULT = 32'h8002_0000;
  localparam int          INSTR_W         = 32;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO holding {pc, instr} pairs.
// Flush empties it in one cycle and overrides a same-cycle push.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic [PW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// PC owner, imem request issue and prefetch queue front end.
// Optional FETCH_PERF_EN adds dequeue and redirect counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = INSTR_W,
  parameter int                QUEUE_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] PC_BASE_ADDR = ADDR_W'(PC_BASE_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        infl_pc;
  logic                     inflight;
  logic                     issue;
  logic                     deq;
  logic                     push;
  logic [CW-1:0]            count;
  logic [ADDR_W+DATA_W-1:0] head;

  assign deq  = instr_valid && instr_ready;
  assign push = inflight && !redirect;

  // Credit counts the outstanding read; a same-cycle dequeue is not credited.
  assign issue = (state == RUN) && !redirect &&
                 ((count + CW'(inflight)) < CW'(QUEUE_DEPTH));

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      if (state == DRAIN) state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (fetch_en) state_nxt = RUN;
        RUN:     if (!fetch_en) state_nxt = DRAIN;
        DRAIN: begin
          if (fetch_en)       state_nxt = RUN;
          else if (!inflight) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= PC_BASE_ADDR;
      infl_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (redirect) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (issue) begin
        pc      <= pc + ADDR_W'(4);
        infl_pc <= pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({infl_pc, imem_rdata}),
    .pop       (deq),
    .flush     (redirect),
    .head_data (head),
    .count     (count)
  );

  assign imem_en     = issue;
  assign imem_addr   = issue ? (pc - PC_BASE_ADDR) : '0;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head[DATA_W-1:0] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (deq)      perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases with hand-computed
// expected {pc, instr} pairs; memory word k holds value k.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h8002_0000;

  logic        clock;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = -3;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial imem_rdata = '0;
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= {2'b00, imem_addr[31:2]};
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic at(input int k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic at_neg(input int k);
    at(k);
    @(negedge clock);
  endtask

  task automatic push_seq(input logic [31:0] pc0, input logic [31:0] d0,
                          input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = pc0 + 32'(4 * i);
      e.data = d0 + 32'(i);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_deq pc=%h data=%h want=none",
                 instr_pc, instr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("deq_pc", instr_pc, e.pc);
        chk("deq_data", instr_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    #2;
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);

    at(-2);
    reset = 1'b1;

    // streaming from reset
    at(0);
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    push_seq(BASE, 32'd0, 5);
    @(negedge clock);
    chk("first_req_c0", 32'(imem_en), 32'd0);
    at_neg(1);
    chk("first_req_c1", 32'(imem_en), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    at_neg(2);
    chk("valid_c2", 32'(instr_valid), 32'd0);
    at_neg(3);
    chk("valid_c3", 32'(instr_valid), 32'd1);

    // back-pressure: queue fills with pcs 14..20
    at(8);
    instr_ready = 1'b0;
    for (int k = 10; k <= 17; k++) begin
      at_neg(k);
      chk("stall_no_req", 32'(imem_en), 32'd0);
    end
    chk("stall_pc", instr_pc, BASE + 32'h14);
    chk("stall_data", instr_data, 32'd5);

    at(18);
    instr_ready = 1'b1;
    push_seq(BASE + 32'h14, 32'd5, 9);

    // redirect together with a handshake on pc 34
    at(26);
    redirect    = 1'b1;
    redirect_pc = BASE + 32'h43;
    push_seq(BASE + 32'h40, 32'h10, 5);
    @(negedge clock);
    chk("redir_no_req", 32'(imem_en), 32'd0);
    at(27);
    redirect = 1'b0;
    @(negedge clock);
    chk("redir_valid_n1", 32'(instr_valid), 32'd0);
    chk("redir_req", 32'(imem_en), 32'd1);
    chk("redir_addr", imem_addr, 32'h40);

    // stop fetching: pc 50 still in flight, then idle
    at(31);
    fetch_en = 1'b0;
    for (int k = 32; k <= 37; k++) begin
      at_neg(k);
      chk("drain_no_req", 32'(imem_en), 32'd0);
    end
    chk("drain_empty", 32'(instr_valid), 32'd0);

    at(38);
    fetch_en = 1'b1;
    push_seq(BASE + 32'h54, 32'h15, 4);
    at_neg(39);
    chk("resume_addr", imem_addr, 32'h54);

    // asynchronous reset pulse mid-stream
    at(45);
    reset = 1'b0;
    #1;
    chk("arst_imem_en", 32'(imem_en), 32'd0);
    chk("arst_imem_addr", imem_addr, 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_data", instr_data, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    #2;
    reset = 1'b1;
    push_seq(BASE, 32'd0, 2);
    at_neg(46);
    chk("restart_req", 32'(imem_en), 32'd1);
    chk("restart_addr", imem_addr, 32'd0);

    at(50);
    instr_ready = 1'b0;
    fetch_en    = 1'b0;

    at_neg(55);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
